axi_burst_slave_mem: RTL

AXI4 burst responder with an internal word-addressed memory array. It sits at the far end of an AXI4 link opposite `axi_burst_master` / `abm_w_fifo` and serves as the on-chip target and simulation memory for that master. It serves one transaction at a time (write or read) with round-robin arbitration. Optional back-pressure inputs let the bench stall the data channels.

---
 rtl/axi_burst_slave_mem_if.sv | 80 ++++++++
 rtl/axi_burst_slave_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_slave_mem_if
// Description : AXI4 bus bundle between a burst master and axi_burst_slave_mem.
//               The slave modport is the memory side; master is the initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_burst_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Write address channel
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic [2:0]          s_axi_awprot;
    logic [3:0]          s_axi_awcache;
    logic                s_axi_awlock;
    logic [3:0]          s_axi_awqos;
    logic [3:0]          s_axi_awregion;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    // Write data / response channels
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wlast;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    // Read address channel
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic [7:0]          s_axi_arlen;
    logic [2:0]          s_axi_arsize;
    logic [1:0]          s_axi_arburst;
    logic [2:0]          s_axi_arprot;
    logic [3:0]          s_axi_arcache;
    logic                s_axi_arlock;
    logic [3:0]          s_axi_arqos;
    logic [3:0]          s_axi_arregion;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    // Read data channel
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rlast;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awprot,
               s_axi_awcache, s_axi_awlock, s_axi_awqos, s_axi_awregion, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_wlast,
        output s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
               s_axi_arcache, s_axi_arlock, s_axi_arqos, s_axi_arregion, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rlast,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awprot,
               s_axi_awcache, s_axi_awlock, s_axi_awqos, s_axi_awregion, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_wlast,
        input  s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
               s_axi_arcache, s_axi_arlock, s_axi_arqos, s_axi_arregion, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rlast,
        output s_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_burst_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_slave_mem
// Description : AXI4 burst target backed by a word-addressed memory array.
//               Serves one write or read burst at a time, round-robin between
//               AW and AR on a tie. stall_w / stall_r throttle the data paths.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic              stall_w,
    input  wire logic              stall_r,
    axi_burst_slave_mem_if.slave   bus
);
    localparam int              c_bpb    = DATA_W / 8;
    localparam int              c_lsb    = $clog2(c_bpb);
    localparam int              c_word_w = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0] c_depth  = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [1:0]      c_okay   = 2'b00;
    localparam logic [1:0]      c_slverr = 2'b10;
    localparam logic [1:0]      c_decerr = 2'b11;
    localparam logic [1:0]      c_incr   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_last_grant_w;   // 1 = write won the last arbitration
    logic [c_word_w-1:0]   r_word;
    logic [7:0]            r_len;
    logic [8:0]            r_cnt;            // beats accepted (write) / loaded (read)
    logic                  r_incr;
    logic [1:0]            r_err;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_W-1:0]     r_mem [MEM_DEPTH];

    // Arbitration: a tie goes to the channel that did not win last time
    logic w_grant_w, w_aw_hs, w_ar_hs;
    assign w_grant_w = bus.s_axi_awvalid & (~bus.s_axi_arvalid | ~r_last_grant_w);
    assign bus.s_axi_awready = (r_state == S_IDLE) & w_grant_w;
    assign bus.s_axi_arready = (r_state == S_IDLE) & bus.s_axi_arvalid & ~w_grant_w;
    assign w_aw_hs = bus.s_axi_awvalid & bus.s_axi_awready;
    assign w_ar_hs = bus.s_axi_arvalid & bus.s_axi_arready;

    // Command of whichever channel is being granted, and its error classification
    logic [ADDR_W-1:0]   w_ax_addr, w_ax_word_full;
    logic [7:0]          w_ax_len;
    logic [2:0]          w_ax_size;
    logic [1:0]          w_ax_burst, w_ax_err;
    logic [ADDR_W:0]     w_ax_end;
    logic [c_word_w-1:0] w_ax_word;
    assign w_ax_addr      = w_grant_w ? bus.s_axi_awaddr  : bus.s_axi_araddr;
    assign w_ax_len       = w_grant_w ? bus.s_axi_awlen   : bus.s_axi_arlen;
    assign w_ax_size      = w_grant_w ? bus.s_axi_awsize  : bus.s_axi_arsize;
    assign w_ax_burst     = w_grant_w ? bus.s_axi_awburst : bus.s_axi_arburst;
    assign w_ax_word_full = w_ax_addr >> c_lsb;
    assign w_ax_word      = w_ax_word_full[c_word_w-1:0];
    assign w_ax_end       = {1'b0, w_ax_word_full}
                          + {{(ADDR_W-7){1'b0}}, (w_ax_burst == c_incr) ? w_ax_len : 8'd0};

    // Unsupported size/burst is a slave error; a burst running off the array is a decode error
    always_comb begin
        if (w_ax_size != 3'(c_lsb) || w_ax_burst[1]) begin
            w_ax_err = c_slverr;
        end else if (w_ax_end >= c_depth) begin
            w_ax_err = c_decerr;
        end else begin
            w_ax_err = c_okay;
        end
    end

    // Write beat qualification; a wlast that disagrees with the beat count poisons the burst
    logic w_last_beat, w_w_hs, w_wlast_bad, w_mem_we;
    assign w_last_beat      = ({1'b0, r_len} == r_cnt);
    assign bus.s_axi_wready = (r_state == S_WDATA) & ~stall_w;
    assign w_w_hs           = bus.s_axi_wvalid & bus.s_axi_wready;
    assign w_wlast_bad      = bus.s_axi_wlast != w_last_beat;
    assign w_mem_we         = w_w_hs & (r_err == c_okay) & ~w_wlast_bad;
    assign bus.s_axi_bvalid = (r_state == S_WRESP);
    assign bus.s_axi_bresp  = (r_state == S_WRESP) ? r_err : c_okay;

    // Read beat source: beat 0 comes straight from the AR command so it appears next cycle
    logic                w_r_load, w_r_first, w_r_hs_last, w_rd_last;
    logic [c_word_w-1:0] w_rd_word;
    logic [1:0]          w_rd_err;
    assign w_r_first   = w_ar_hs & ~stall_r;
    assign w_r_load    = w_r_first
                       | ((r_state == S_RDATA) & (~r_rvalid | bus.s_axi_rready)
                          & (r_cnt <= {1'b0, r_len}) & ~stall_r);
    assign w_rd_word   = (r_state == S_IDLE) ? w_ax_word : r_word;
    assign w_rd_err    = (r_state == S_IDLE) ? w_ax_err : r_err;
    assign w_rd_last   = (r_state == S_IDLE) ? (w_ax_len == 8'd0) : w_last_beat;
    assign w_r_hs_last = (r_state == S_RDATA) & r_rvalid & bus.s_axi_rready & r_rlast;

    assign bus.s_axi_rvalid = r_rvalid;
    assign bus.s_axi_rdata  = r_rdata;
    assign bus.s_axi_rlast  = r_rlast;
    assign bus.s_axi_rresp  = r_rresp;

    // Transaction FSM: command capture, beat counting, address advance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_last_grant_w <= 1'b0;
            r_word         <= '0;
            r_len          <= 8'd0;
            r_cnt          <= 9'd0;
            r_incr         <= 1'b0;
            r_err          <= c_okay;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs || w_ar_hs) begin
                        r_len          <= w_ax_len;
                        r_incr         <= (w_ax_burst == c_incr);
                        r_err          <= w_ax_err;
                        r_last_grant_w <= w_aw_hs;
                        r_cnt          <= w_r_first ? 9'd1 : 9'd0;
                        r_word         <= (w_r_first && w_ax_burst == c_incr)
                                          ? w_ax_word + c_word_w'(1) : w_ax_word;
                        r_state        <= w_aw_hs ? S_WDATA : S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (w_w_hs) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (r_incr) begin
                            r_word <= r_word + c_word_w'(1);
                        end
                        if (w_wlast_bad) begin
                            r_err <= c_slverr;
                        end
                        if (w_last_beat) begin
                            r_state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (bus.s_axi_bready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (w_r_load) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (r_incr) begin
                            r_word <= r_word + c_word_w'(1);
                        end
                    end
                    if (w_r_hs_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read beat register: load the next beat when the slot is free, retire it on handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rlast  <= 1'b0;
            r_rresp  <= c_okay;
        end else if (w_r_load) begin
            r_rvalid <= 1'b1;
            r_rdata  <= (w_rd_err == c_okay) ? r_mem[w_rd_word] : '0;
            r_rlast  <= w_rd_last;
            r_rresp  <= w_rd_err;
        end else if (r_rvalid && bus.s_axi_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end
    end

    // Byte-masked array write for accepted, error-free beats; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_bpb; i++) begin
                if (bus.s_axi_wstrb[i]) begin
                    r_mem[r_word][i*8 +: 8] <= bus.s_axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Sideband fields that carry no meaning for this target
    logic w_unused;
    assign w_unused = ^{bus.s_axi_awprot, bus.s_axi_awcache, bus.s_axi_awlock, bus.s_axi_awqos,
                        bus.s_axi_awregion, bus.s_axi_arprot, bus.s_axi_arcache, bus.s_axi_arlock,
                        bus.s_axi_arqos, bus.s_axi_arregion};
endmodule
`default_nettype wire
